// File: rtl/duft_arb_pkg.sv
// Shared types and constants for the DUFT round-robin arbiter.
// Bus widths, the DUFT idle-address sentinel and the arbiter state encoding.
package duft_arb_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] DUFT_IDLE_ADDR = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/duft_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester searching upward
// from last_grant+1, wrapping at NREQ. Returns a one-hot grant and a found flag.
module rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] valid,
   input  logic [GW-1:0]   last_grant,
   output logic [NREQ-1:0] grant,
   output logic            found
);

   logic [GW-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = GW'((32'(last_grant) + k) % NREQ);
         if (!found && valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/duft_rr_arbiter.sv
// Round-robin arbiter sharing one ap_ctrl_hs DUFT between NREQ requesters.
// Grants one transaction at a time, sequences ap_start/ap_done and returns a one-cycle response.
module duft_rr_arbiter
   import duft_arb_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_rd_wr,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wr_data,
   output logic [NREQ-1:0]        req_ready,
   output logic [NREQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]      resp_data,
   output logic                   resp_err,
   output logic                   duft_start,
   output logic                   duft_rd_wr,
   output logic [ADDR_W-1:0]      duft_addr,
   output logic [DATA_W-1:0]      duft_wr_data,
   input  logic                   duft_idle,
   input  logic                   duft_done,
   input  logic [DATA_W-1:0]      duft_return
);

   localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   arb_state_t          state, state_nxt;
   logic [GW-1:0]       last_grant;
   logic [CW-1:0]       cnt;
   logic                rd_wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wr_data_q;
   logic [DATA_W-1:0]   resp_data_q;
   logic                err_q;

   logic [NREQ-1:0]     pick;
   logic                found;
   logic [GW-1:0]       g_idx;
   logic                accept;
   logic                timeout_hit;

   logic [ADDR_W-1:0]   addr_a  [NREQ];
   logic [DATA_W-1:0]   wdata_a [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
      assign wdata_a[i] = req_wr_data[i*DATA_W +: DATA_W];
   end

   rr_pick #(
      .NREQ (NREQ),
      .GW   (GW)
   ) u_pick (
      .valid      (req_valid),
      .last_grant (last_grant),
      .grant      (pick),
      .found      (found)
   );

   always_comb begin
      g_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick[GW'(i)]) g_idx = GW'(i);
      end
   end

   // Reset gates the grant so no requester sees ready for a transfer that never lands.
   assign accept      = (state == ST_IDLE) && duft_idle && found && !reset;
   assign timeout_hit = !duft_done && (cnt == CNT_LAST);

   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      resp_valid = '0;
      duft_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               req_ready = pick;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            duft_start = 1'b1;
            if (duft_done || timeout_hit) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            resp_valid[last_grant] = 1'b1;
            state_nxt              = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         last_grant  <= LAST_RST;
         cnt         <= '0;
         rd_wr_q     <= 1'b0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         resp_data_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  rd_wr_q    <= req_rd_wr[g_idx];
                  addr_q     <= addr_a[g_idx];
                  wr_data_q  <= wdata_a[g_idx];
                  last_grant <= g_idx;
                  cnt        <= '0;
               end
            end
            ST_BUSY: begin
               if (duft_done) begin
                  resp_data_q <= rd_wr_q ? duft_return : '0;
                  err_q       <= 1'b0;
               end else if (timeout_hit) begin
                  resp_data_q <= '0;
                  err_q       <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign resp_data    = resp_data_q;
   assign resp_err     = err_q;
   assign duft_rd_wr   = rd_wr_q;
   assign duft_addr    = addr_q;
   assign duft_wr_data = wr_data_q;

endmodule

// File: tb/tb_duft_rr_arbiter.sv
// Directed bench for duft_rr_arbiter with a small ap_ctrl_hs DUFT model
// (read done 1 cycle after start is seen, write done 2 cycles after, optional hang).
module tb_duft_rr_arbiter;
   import duft_arb_pkg::*;

   logic         clk;
   logic         reset;
   logic [3:0]   req_valid;
   logic [3:0]   req_rd_wr;
   logic [127:0] req_addr;
   logic [127:0] req_wr_data;
   logic [3:0]   req_ready;
   logic [3:0]   resp_valid;
   logic [31:0]  resp_data;
   logic         resp_err;
   logic         duft_start;
   logic         duft_rd_wr;
   logic [31:0]  duft_addr;
   logic [31:0]  duft_wr_data;
   logic         duft_idle;
   logic         duft_done;
   logic [31:0]  duft_return;

   logic [31:0]  a_addr  [4];
   logic [31:0]  a_wdata [4];
   logic         stuck;

   int n_vec;
   int n_err;

   assign req_addr    = {a_addr[3], a_addr[2], a_addr[1], a_addr[0]};
   assign req_wr_data = {a_wdata[3], a_wdata[2], a_wdata[1], a_wdata[0]};

   duft_rr_arbiter #(
      .NREQ    (4),
      .TIMEOUT (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_rd_wr    (req_rd_wr),
      .req_addr     (req_addr),
      .req_wr_data  (req_wr_data),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .resp_err     (resp_err),
      .duft_start   (duft_start),
      .duft_rd_wr   (duft_rd_wr),
      .duft_addr    (duft_addr),
      .duft_wr_data (duft_wr_data),
      .duft_idle    (duft_idle),
      .duft_done    (duft_done),
      .duft_return  (duft_return)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DUFT model
   typedef enum logic [2:0] {M_RST, M_IDLE, M_WR, M_DONE, M_HANG} mst_t;
   mst_t        mst;
   logic [31:0] mem [256];
   logic [31:0] m_ret;

   always_ff @(posedge clk) begin
      if (reset) begin
         mst          <= M_RST;
         m_ret        <= '0;
         mem[8'h10]   <= 32'h1234_5678;
      end else begin
         case (mst)
            M_RST:  mst <= M_IDLE;
            M_IDLE: begin
               if (duft_start) begin
                  if (stuck) mst <= M_HANG;
                  else if (duft_rd_wr) begin
                     m_ret <= mem[duft_addr[7:0]];
                     mst   <= M_DONE;
                  end else mst <= M_WR;
               end
            end
            M_WR: begin
               mem[duft_addr[7:0]] <= duft_wr_data;
               m_ret               <= 32'hBAD0_0BAD;
               mst                 <= M_DONE;
            end
            M_DONE: mst <= M_IDLE;
            M_HANG: if (!stuck) mst <= M_IDLE;
            default: mst <= M_RST;
         endcase
      end
   end

   assign duft_idle   = (mst == M_IDLE);
   assign duft_done   = (mst == M_DONE);
   assign duft_return = (mst == M_DONE) ? m_ret : DUFT_IDLE_ADDR;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic post(input logic [1:0] i, input logic rd, input logic [31:0] a, input logic [31:0] d);
      a_addr[i]    = a;
      a_wdata[i]   = d;
      req_rd_wr[i] = rd;
      req_valid[i] = 1'b1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      reset     = 1'b1;
      repeat (2) nxt();
      reset     = 1'b0;
   endtask

   task automatic wait_ready(input logic [1:0] i, input int lim, output bit got);
      got = 1'b0;
      for (int k = 0; k < lim; k++) begin
         #1;
         if (req_ready[i]) begin
            got = 1'b1;
            break;
         end
         nxt();
      end
   endtask

   function automatic int oh2idx(input logic [3:0] v);
      case (v)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return -1;
      endcase
   endfunction

   // Posts one transaction, checks grant, DUFT drive, latency and response; returns in the RESP cycle.
   task automatic do_txn(input logic [1:0] i, input logic rd, input logic [31:0] a, input logic [31:0] d,
                         input int exp_lat, input logic [31:0] exp_data, input logic exp_err, input string tag);
      bit got;
      bit seen;
      int lat;
      post(i, rd, a, d);
      wait_ready(i, 40, got);
      chk({tag, "_ready"}, 32'(got), 32'd1);
      chk({tag, "_ready_onehot"}, 32'(req_ready), 32'(4'b0001 << i));
      nxt();
      req_valid[i] = 1'b0;
      chk({tag, "_start"}, 32'(duft_start), 32'd1);
      chk({tag, "_duft_addr"}, duft_addr, a);
      chk({tag, "_duft_rdwr"}, 32'(duft_rd_wr), 32'(rd));
      if (!rd) chk({tag, "_duft_wdata"}, duft_wr_data, d);
      lat  = 1;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (|resp_valid) begin
            seen = 1'b1;
            break;
         end
         nxt();
         lat++;
      end
      chk({tag, "_resp_seen"}, 32'(seen), 32'd1);
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_resp_onehot"}, 32'(resp_valid), 32'(4'b0001 << i));
      chk({tag, "_resp_data"}, resp_data, exp_data);
      chk({tag, "_resp_err"}, 32'(resp_err), 32'(exp_err));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] first;
      int         order [6];
      int         tacc  [6];
      int         nacc;
      int         nresp;
      int         bad3;
      int         ok1;
      int         blocked;
      bit         got;

      n_vec = 0;
      n_err = 0;
      stuck = 1'b0;
      req_valid = '0;
      req_rd_wr = '0;
      for (int j = 0; j < 4; j++) begin
         a_addr[j]  = '0;
         a_wdata[j] = '0;
      end
      reset = 1'b1;

      // 1: reset state, DUFT RST cycle, first read
      repeat (2) nxt();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_start", 32'(duft_start), 32'd0);
      chk("rst_duft_addr", duft_addr, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      reset = 1'b0;
      post(2'd0, 1'b1, 32'h10, 32'h0);
      #1;
      chk("rstcyc_no_grant", 32'(req_ready), 32'd0);
      do_txn(2'd0, 1'b1, 32'h10, 32'h0, 3, 32'h1234_5678, 1'b0, "rd0");

      // 2: write then read back
      do_txn(2'd1, 1'b0, 32'h20, 32'hDEAD_BEEF, 4, 32'h0, 1'b0, "wr1");
      do_txn(2'd1, 1'b1, 32'h20, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, "rd1");

      // 3: all four requesters hold valid
      nxt();
      do_reset();
      for (int j = 0; j < 4; j++) post(2'(j), 1'b1, 32'h10, 32'h0);
      nacc = 0;
      for (int k = 0; k < 60; k++) begin
         #1;
         if (|req_ready) begin
            order[nacc] = oh2idx(req_ready);
            tacc[nacc]  = k;
            nacc++;
            if (nacc == 6) break;
         end
         nxt();
      end
      nxt();
      req_valid = '0;
      chk("rr_accepts", 32'(nacc), 32'd6);
      for (int j = 0; j < 6; j++) begin
         chk($sformatf("rr_order%0d", j), 32'(order[j]), 32'(j % 4));
         if (j > 0) chk($sformatf("rr_gap%0d", j), 32'(tacc[j] - tacc[j-1]), 32'd4);
      end
      repeat (6) nxt();

      // 4: DUFT never completes
      stuck = 1'b1;
      do_txn(2'd2, 1'b1, 32'h10, 32'h0, 17, 32'h0, 1'b1, "tmo");
      post(2'd3, 1'b1, 32'h10, 32'h0);
      blocked = 0;
      for (int k = 0; k < 10; k++) begin
         nxt();
         blocked += int'(|req_ready);
      end
      chk("tmo_no_grant", 32'(blocked), 32'd0);
      stuck = 1'b0;
      do_txn(2'd3, 1'b1, 32'h10, 32'h0, 3, 32'h1234_5678, 1'b0, "tmo_recover");

      // 5: reset in the second BUSY cycle of a write
      nxt();
      post(2'd2, 1'b0, 32'h30, 32'hA5A5_5A5A);
      wait_ready(2'd2, 20, got);
      chk("kill_ready", 32'(got), 32'd1);
      nxt();
      req_valid[2] = 1'b0;
      nxt();
      reset = 1'b1;
      nxt();
      reset = 1'b0;
      chk("kill_start", 32'(duft_start), 32'd0);
      post(2'd0, 1'b1, 32'h10, 32'h0);
      post(2'd2, 1'b1, 32'h10, 32'h0);
      first = '0;
      nresp = 0;
      for (int k = 0; k < 20; k++) begin
         #1;
         nresp += int'(|resp_valid);
         if (|req_ready) begin
            first = req_ready;
            break;
         end
         nxt();
      end
      chk("kill_no_resp", 32'(nresp), 32'd0);
      chk("kill_first_grant", 32'(first), 32'b0001);
      nxt();
      req_valid[0] = 1'b0;
      wait_ready(2'd2, 20, got);
      chk("kill_second_grant", 32'(got), 32'd1);
      nxt();
      req_valid[2] = 1'b0;
      repeat (6) nxt();

      // 6: requester 3 withdraws, requester 1 wins
      do_txn(2'd0, 1'b1, 32'h20, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, "wd_rd0");
      post(2'd3, 1'b1, 32'h10, 32'h0);
      post(2'd1, 1'b1, 32'h10, 32'h0);
      #1;
      chk("wd_resp_no_grant", 32'(req_ready), 32'd0);
      nxt();
      chk("wd_grant1", 32'(req_ready), 32'b0010);
      req_valid[3] = 1'b0;
      bad3 = 0;
      ok1  = 0;
      nxt();
      req_valid[1] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         bad3 += int'(req_ready[3]) + int'(resp_valid[3]);
         ok1  += int'(resp_valid[1]);
         nxt();
      end
      chk("wd_req3_untouched", 32'(bad3), 32'd0);
      chk("wd_resp1", 32'(ok1), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
